// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Multicycle-MIPS instruction fetch and PC read side. On start, the PC is
//   sampled into pc_q and classified (misaligned / outside the text segment /
//   fetchable). A fetchable PC issues one word read over a req/ack handshake.
//   The instruction register is loaded on ack. A one-cycle
//   instr_valid/pc_enable pulse then hands pc_next back to the PC register.
//   Faults are sticky until clear_fault.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start               fetch request, sampled only while idle
//   clear_fault         leave the fault state (ignored elsewhere)
//   pc_in               current PC from the PC register
//   mem_rdata, mem_ack  memory read data / read-complete strobe
//   mem_req, mem_addr   memory read request and word address
//   instr_out           instruction register
//   instr_valid         one-cycle pulse when a new instruction is latched
//   pc_enable           one-cycle PC register write enable
//   pc_next             pc_q + 4
//   busy                not idle
//   fault, fault_code   sticky fault flag and cause (01 misaligned,
//                       10 out of range, 11 timeout)
module instr_fetch_unit #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] TEXT_BASE   = 32'h0040_0000,
  parameter int                     ADDR_BITS   = 10,
  parameter int                     TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear_fault,
  input  logic [WORD_LENGTH-1:0] pc_in,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [WORD_LENGTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   pc_enable,
  output logic [WORD_LENGTH-1:0] pc_next,
  output logic                   busy,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  // Segment size in bytes. One extra bit keeps the compare exact even when
  // the segment would fill the whole address space.
  localparam logic [WORD_LENGTH:0] SEG_BYTES = (WORD_LENGTH+1)'(1) << (ADDR_BITS + 2);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t                 state;
  logic [WORD_LENGTH-1:0] pc_q;
  logic [CW-1:0]          wait_cnt;

  logic [WORD_LENGTH-1:0] in_offset;
  logic                   in_misaligned;
  logic                   in_out_of_range;

  assign in_offset       = pc_in - TEXT_BASE;
  assign in_misaligned   = (pc_in[1:0] != 2'b00);
  assign in_out_of_range = (pc_in < TEXT_BASE) || ({1'b0, in_offset} >= SEG_BYTES);

  assign pc_next = pc_q + WORD_LENGTH'(4);
  // The low address bits of a difference only depend on the low bits of its
  // operands, so the word address is taken from the narrow subtraction.
  assign mem_addr = pc_q[ADDR_BITS+1:2] - TEXT_BASE[ADDR_BITS+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc_q        <= TEXT_BASE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_enable   <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      // Pulses last exactly one cycle; only the REQ->DONE edge sets them.
      instr_valid <= 1'b0;
      pc_enable   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc_q <= pc_in;
            busy <= 1'b1;
            if (in_misaligned) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= FC_MISALIGN;
            end else if (in_out_of_range) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= FC_RANGE;
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        REQ: begin
          // Ack is tested first so that it wins against a same-cycle timeout.
          if (mem_ack) begin
            state       <= DONE;
            mem_req     <= 1'b0;
            instr_out   <= mem_rdata;
            instr_valid <= 1'b1;
            pc_enable   <= 1'b1;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state      <= FAULT;
            mem_req    <= 1'b0;
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        FAULT: begin
          if (clear_fault) begin
            state      <= IDLE;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state      <= IDLE;
          mem_req    <= 1'b0;
          busy       <= 1'b0;
          fault      <= 1'b0;
          fault_code <= FC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Randomized fetch transactions against a transaction-level model. The
//   model works from the documented latencies: req for w+1 cycles, then a
//   done pulse; or TIMEOUT req cycles, then a fault. It sets the expected
//   outputs cycle by cycle. A compare process checks every output one time
//   unit after each rising edge. Directed literal checks pin the model.
module tb_instr_fetch_unit;

  localparam logic [31:0] TBASE = 32'h0040_0000;
  localparam int          AB    = 10;
  localparam int          TO    = 15;

  logic        clk = 1'b0;
  logic        reset, start, clear_fault, mem_ack;
  logic [31:0] pc_in, mem_rdata;
  logic        mem_req, instr_valid, pc_enable, busy, fault;
  logic [AB-1:0] mem_addr;
  logic [31:0] instr_out, pc_next;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  // model state and expected per-cycle flags
  logic [31:0] m_pc, m_instr;
  logic        e_req, e_valid, e_busy, e_fault;
  logic [1:0]  e_code, cur_code;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .WORD_LENGTH(32), .TEXT_BASE(TBASE), .ADDR_BITS(AB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear_fault(clear_fault),
    .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_enable(pc_enable), .pc_next(pc_next),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic rq, input logic vl, input logic bs,
                         input logic ft, input logic [1:0] cd);
    e_req = rq; e_valid = vl; e_busy = bs; e_fault = ft; e_code = cd;
  endtask

  function automatic logic [1:0] classify(input logic [31:0] pc);
    longint unsigned p;
    p = 64'(pc);
    if (p % 4 != 0) return 2'd1;
    if (p < 64'(TBASE) || p >= 64'(TBASE) + 4 * (64'd1 << AB)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_addr();
    logic [31:0] d;
    d = m_pc - TBASE;
    return (d >> 2) & ((32'd1 << AB) - 32'd1);
  endfunction

  // single compare process: every output, every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("mem_req",     32'(mem_req),     32'(e_req));
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("pc_enable",   32'(pc_enable),   32'(e_valid));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("fault",       32'(fault),       32'(e_fault));
      chk("fault_code",  32'(fault_code),  32'(e_code));
      chk("instr_out",   instr_out,        m_instr);
      chk("pc_next",     pc_next,          m_pc + 32'd4);
      chk("mem_addr",    32'(mem_addr),    exp_addr());
    end
  end

  // One fetch attempt starting from IDLE. w = wait cycles before ack;
  // w >= TO means no ack. Ends with the model describing the cycle after
  // DONE (idle) or the first FAULT cycle.
  task automatic do_txn(input logic [31:0] pc, input int w, input logic [31:0] rd);
    logic [1:0] code;
    bit acked;
    acked = 0;
    code  = classify(pc);
    @(negedge clk);
    start = 1'b1; pc_in = pc; clear_fault = 1'($urandom % 2);
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    m_pc = pc;
    $display("txn pc=%h wait=%0d class=%0d", pc, w, code);
    if (code != 2'd0) begin
      cur_code = code;
      set_exp(1'b0, 1'b0, 1'b1, 1'b1, code);
      return;
    end
    set_exp(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      start = 1'($urandom % 2); pc_in = $urandom; clear_fault = 1'($urandom % 2);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (k == w + 1) begin
        mem_ack = 1'b1; mem_rdata = rd; m_instr = rd;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        acked = 1;
        break;
      end else if (k == TO) begin
        cur_code = 2'd3;
        set_exp(1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
      end else begin
        set_exp(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      end
    end
    if (acked) begin
      // DONE cycle: start and ack must both be ignored here
      @(negedge clk);
      start = 1'($urandom % 2); pc_in = $urandom; mem_ack = 1'($urandom % 2);
      clear_fault = 1'($urandom % 2);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
  endtask

  task automatic fault_clear(input bit with_start);
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'($urandom % 2); clear_fault = 1'b0;
      mem_ack = 1'($urandom % 2); pc_in = $urandom; mem_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b1, 1'b1, cur_code);
    end
    @(negedge clk);
    clear_fault = 1'b1; start = with_start ? 1'b1 : 1'($urandom % 2);
    pc_in = TBASE + 32'h10; mem_ack = 1'($urandom % 2);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic idle_gap(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; clear_fault = 1'($urandom % 2);
      mem_ack = stray_ack ? 1'b1 : 1'($urandom % 2);
      mem_rdata = $urandom; pc_in = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int w, r;
    reset = 1'b0; start = 1'b0; clear_fault = 1'b0; mem_ack = 1'b0;
    pc_in = '0; mem_rdata = '0;
    m_pc = TBASE; m_instr = '0; cur_code = 2'd0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_pc_next", pc_next, 32'h0040_0004);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    reset = 1'b1;
    idle_gap(2, 1'b0);

    // zero-wait fetch
    do_txn(32'h0040_0008, 0, 32'h2008_0005);
    @(posedge clk); #2;
    chk("zw_instr_out", instr_out, 32'h2008_0005);
    chk("zw_pc_next", pc_next, 32'h0040_000C);
    chk("zw_mem_addr", 32'(mem_addr), 32'd2);

    // misaligned and out-of-range faults leave instr_out alone
    do_txn(32'h0040_0002, 0, 32'hDEAD_0001);
    @(posedge clk); #2;
    chk("mis_code", 32'(fault_code), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_instr", instr_out, 32'h2008_0005);
    fault_clear(1'b0);
    do_txn(32'h0040_1000, 0, 32'hDEAD_0002);
    @(posedge clk); #2;
    chk("hi_code", 32'(fault_code), 32'd2);
    chk("hi_instr", instr_out, 32'h2008_0005);
    fault_clear(1'b0);
    do_txn(32'h003F_FFFC, 0, 32'hDEAD_0003);
    @(posedge clk); #2;
    chk("lo_code", 32'(fault_code), 32'd2);
    chk("lo_instr", instr_out, 32'h2008_0005);
    fault_clear(1'b0);

    // wait states, last valid word, timeout, clear with start, race
    do_txn(TBASE + 32'h40, 3, 32'h1234_5678);
    do_txn(TBASE + 32'd4092, 1, 32'hCAFE_F00D);
    do_txn(TBASE + 32'h80, TO, 32'h0);
    @(posedge clk); #2;
    chk("to_code", 32'(fault_code), 32'd3);
    chk("to_instr", instr_out, 32'hCAFE_F00D);
    fault_clear(1'b1);
    @(posedge clk); #2;
    chk("clr_start_busy", 32'(busy), 32'd0);
    do_txn(TBASE + 32'hC0, TO - 1, 32'h0BAD_CAFE);
    @(posedge clk); #2;
    chk("race_instr", instr_out, 32'h0BAD_CAFE);
    chk("race_fault", 32'(fault), 32'd0);

    // async reset in the 2nd REQ cycle, then stray acks in idle
    @(negedge clk);
    start = 1'b1; pc_in = TBASE + 32'h100; mem_ack = 1'b0; clear_fault = 1'b0;
    m_pc = TBASE + 32'h100;
    set_exp(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_pc = TBASE; m_instr = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_instr", instr_out, 32'd0);
    chk("arst_pc_next", pc_next, 32'h0040_0004);
    @(negedge clk);
    reset = 1'b1;
    idle_gap(3, 1'b1);
    @(posedge clk); #2;
    chk("stray_instr", instr_out, 32'd0);

    // randomized transactions
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pc = TBASE + 4 * $urandom_range(0, 1023);
        3:       pc = TBASE + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
        4:       pc = ($urandom % 2) ? TBASE + 32'd4096 + 4 * $urandom_range(0, 100)
                                     : TBASE - 4 * $urandom_range(1, 100);
        default: pc = $urandom;
      endcase
      r = $urandom_range(0, 9);
      if (r < 6)       w = $urandom_range(0, 3);
      else if (r == 6) w = TO - 1;
      else if (r == 7) w = TO;
      else             w = $urandom_range(4, TO - 2);
      do_txn(pc, w, $urandom);
      if (e_fault) fault_clear(bit'($urandom % 2));
      if ($urandom % 3 == 0) idle_gap($urandom_range(1, 3), bit'($urandom % 2));
    end
    idle_gap(2, 1'b0);
    @(posedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle-MIPS instruction fetch block and the read side of the program counter. On `start` it samples the current PC, checks alignment and range against the text segment at 0x0040_0000, and fetches one word over a req/ack memory handshake. It then latches the instruction register and returns `pc_next` with a one-cycle `pc_enable` pulse that writes back into the PC register. Faults (misaligned, out of range, memory timeout) are reported as sticky status.

## Interface
- `WORD_LENGTH`, 32: data and PC width.
- `TEXT_BASE`, 32'h0040_0000: byte address of text-segment word 0; also the reset value of the internal PC copy.
- `ADDR_BITS`, 10: memory word-address width; the segment spans 2^ADDR_BITS words.
- `TIMEOUT`, 15: maximum REQ cycles without `mem_ack` before a timeout fault (must be ≥1).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `start` in 1: fetch request; sampled only in IDLE.
- `clear_fault` in 1: leaves FAULT; ignored in any other state.
- `pc_in` in WORD_LENGTH: current PC from the PC register.
- `mem_rdata` in WORD_LENGTH: read data; valid when `mem_ack`=1.
- `mem_ack` in 1: read complete; honoured only in REQ.
- `mem_req` out 1: read request; high for the whole REQ state.
- `mem_addr` out ADDR_BITS: word address, (pc_q − TEXT_BASE)[ADDR_BITS+1:2].
- `instr_out` out WORD_LENGTH: instruction register; holds its value until the next successful fetch.
- `instr_valid` out 1: one-cycle pulse in DONE.
- `pc_enable` out 1: one-cycle pulse in DONE; drives the PC register enable.
- `pc_next` out WORD_LENGTH: pc_q + 4, modulo 2^WORD_LENGTH.
- `busy` out 1: high in any state other than IDLE.
- `fault` out 1: high in FAULT.
- `fault_code` out 2: 00 none, 01 misaligned, 10 out of range, 11 timeout.

## Operation
- The FSM has four states: IDLE, REQ, DONE and FAULT. All registered outputs are driven by the FSM; `pc_next` and `mem_addr` are combinational from `pc_q`.
- **IDLE:** on `start`=1, load `pc_q` ← `pc_in` and classify `pc_in`:
  - `pc_in[1:0]` ≠ 0 → FAULT, code 01. The misaligned check takes priority over the range check.
  - `pc_in` < TEXT_BASE, or (`pc_in` − TEXT_BASE) ≥ 4·2^ADDR_BITS → FAULT, code 10.
  - Otherwise → REQ, with the timeout counter cleared to 0.
- **REQ:** `mem_req`=1 and `mem_addr` is held stable.
  - On `mem_ack`=1: `instr_out` ← `mem_rdata`, then go to DONE.
  - With no ack, the counter increments each cycle. When counter = TIMEOUT−1 and there is still no ack, go to FAULT with code 11.
  - If ack arrives in the same cycle the timeout would fire, the ack wins.
- **DONE:** `instr_valid`=1 and `pc_enable`=1 for exactly one cycle, then return to IDLE unconditionally. `start` is not sampled in DONE.
- **FAULT:** `fault`=1 and `fault_code` is held; `pc_enable` is never asserted. On `clear_fault`=1 go to IDLE with `fault_code` ← 00. `start` is ignored, including when it arrives in the same cycle as `clear_fault`.
- `instr_out` is not modified on any fault.
- `mem_ack` is ignored in IDLE, DONE and FAULT.
- Counter width is $clog2(TIMEOUT)+1 bits; it never wraps.

## Timing
- **Reset values:**
  - State IDLE, `pc_q` = TEXT_BASE, so `pc_next` = 32'h0040_0004 and `mem_addr` = 0.
  - `mem_req`, `instr_valid`, `pc_enable`, `busy` and `fault` all 0.
  - `instr_out` = 0, `fault_code` = 00.
- **Reset mid-operation:** asynchronous; `mem_req` drops immediately and any in-flight fetch is abandoned with no `pc_enable` pulse.
- **Latency:** `start` sampled at edge 0 → `mem_req` high from cycle 1.
  - Ack in cycle 1+w (w wait cycles) → `instr_valid`/`pc_enable` high in cycle 2+w.
  - Minimum start-to-valid latency is 2 cycles; peak throughput is one fetch per 3 cycles.
- **Timeout:** `mem_req` stays high for exactly TIMEOUT cycles with no ack, then `fault` goes high in the next cycle.
- **Fault timing:** fault detection in IDLE takes effect at the edge that samples `start`, so `fault` is high from cycle 1.
- **PC write-back:** `pc_next` is valid whenever `pc_enable`=1. The PC register samples it at the end of the DONE cycle.

## Test plan
- **Zero-wait fetch:** `pc_in`=0x0040_0008, `start` pulse, `mem_ack` in the first REQ cycle with `mem_rdata`=0x2008_0005 → `mem_addr`=2, `instr_out`=0x2008_0005, `pc_next`=0x0040_000C, and `instr_valid`/`pc_enable` high exactly in cycle 2.
- **Wait states:** ack delayed 3 cycles → `mem_req` held 4 cycles with `mem_addr` stable, and the DONE pulse occurs in cycle 5.
- **Misaligned / out-of-range:** `pc_in`=0x0040_0002 → `fault_code`=01 in cycle 1 with no `mem_req`. `pc_in`=0x0040_1000 with ADDR_BITS=10 → `fault_code`=10. `pc_in`=0x003F_FFFC → `fault_code`=10. In all three cases `instr_out` is unchanged.
- **Timeout:** no ack with TIMEOUT=15 → `mem_req` high for 15 cycles, then `fault_code`=11. A `clear_fault` asserted together with `start` returns to IDLE without starting a fetch.
- **Ack/timeout race:** ack arrives exactly on the 15th REQ cycle → normal DONE and no fault.
- **Reset and stray ack:** async reset asserted in the 2nd REQ cycle → `mem_req`=0 immediately and all outputs return to their reset values. A subsequent `mem_ack` seen in IDLE has no effect.
